// File: rtl/gpu_extmem_queue_if.sv
// Core-side request, gateway-side transaction and writeback signals of the
// external memory queue, grouped so the queue and its environment share one bundle.
interface gpu_extmem_queue_if #(
  parameter int unsigned AW = 24
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_reg;

  logic          gw_external;
  logic [AW-1:0] gw_addr;
  logic [31:0]   gw_din;
  logic          gw_memw;
  logic [1:0]    gw_msize;
  logic          gw_done;
  logic          xld_ready;
  logic [31:0]   load_data;

  logic          wb_valid;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          wb_stall;

  // The queue itself
  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, req_reg,
    output req_ready,
    output gw_external, gw_addr, gw_din, gw_memw, gw_msize,
    input  gw_done, xld_ready, load_data,
    output wb_valid, wb_reg, wb_data,
    input  wb_stall
  );

  // Core, gateway and writeback port driving the queue
  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, req_reg,
    input  req_ready,
    input  gw_external, gw_addr, gw_din, gw_memw, gw_msize,
    output gw_done, xld_ready, load_data,
    input  wb_valid, wb_reg, wb_data,
    output wb_stall
  );
endinterface

// File: rtl/gpu_extmem_queue.sv
// In-order external load/store queue: buffers core requests, issues them one at
// a time to the bus gateway and returns zero-extended load results to writeback.
module gpu_extmem_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 24
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  gpu_extmem_queue_if.slave    bus,
  output logic                 busy,
  output logic                 err_align,
  input  logic                 err_clr
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t state_q, state_d;

  logic          fifo_write [DEPTH];
  logic [1:0]    fifo_size  [DEPTH];
  logic [AW-1:0] fifo_addr  [DEPTH];
  logic [31:0]   fifo_din   [DEPTH];
  logic [4:0]    fifo_reg   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          ready;
  logic          push, pop, capture;

  logic [1:0]    size_n;
  logic          misalign;
  logic [AW-1:0] addr_al;
  logic [31:0]   din_rep;

  logic          iss_write;
  logic [1:0]    iss_size;
  logic [AW-1:0] iss_addr;
  logic [31:0]   iss_din;
  logic [4:0]    iss_reg;
  logic [31:0]   wb_data_q;

  assign ready = (count != FULL);
  assign push  = bus.req_valid & ready;

  // Requests are normalised at enqueue: size 3 becomes long, the address is
  // forced aligned and store data is lane-replicated, so issue is a plain copy.
  always_comb begin
    size_n   = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
    misalign = 1'b0;
    addr_al  = bus.req_addr;
    din_rep  = bus.req_wdata;
    case (size_n)
      2'd0: din_rep = {4{bus.req_wdata[7:0]}};
      2'd1: begin
        din_rep  = {2{bus.req_wdata[15:0]}};
        misalign = bus.req_addr[0];
        addr_al  = {bus.req_addr[AW-1:1], 1'b0};
      end
      default: begin
        misalign = (bus.req_addr[1:0] != 2'b00);
        addr_al  = {bus.req_addr[AW-1:2], 2'b00};
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.req_write;
      fifo_size[wr_ptr]  <= size_n;
      fifo_addr[wr_ptr]  <= addr_al;
      fifo_din[wr_ptr]   <= din_rep;
      fifo_reg[wr_ptr]   <= bus.req_reg;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_align <= 1'b0;
    end else if (push && misalign) begin
      err_align <= 1'b1;
    end else if (err_clr) begin
      err_align <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (iss_write) begin
          if (bus.gw_done) state_d = IDLE;
        end else if (bus.xld_ready) begin
          capture = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        if (!bus.wb_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_write <= 1'b0;
      iss_size  <= '0;
      iss_addr  <= '0;
      iss_din   <= '0;
      iss_reg   <= '0;
    end else if (pop) begin
      iss_write <= fifo_write[rd_ptr];
      iss_size  <= fifo_size[rd_ptr];
      iss_addr  <= fifo_addr[rd_ptr];
      iss_din   <= fifo_din[rd_ptr];
      iss_reg   <= fifo_reg[rd_ptr];
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_data_q <= '0;
    end else if (capture) begin
      case (iss_size)
        2'd0:    wb_data_q <= {24'b0, bus.load_data[7:0]};
        2'd1:    wb_data_q <= {16'b0, bus.load_data[15:0]};
        default: wb_data_q <= bus.load_data;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.gw_external = (state_q == XFER);
  assign bus.gw_addr     = iss_addr;
  assign bus.gw_din      = iss_din;
  assign bus.gw_memw     = (state_q == XFER) & iss_write;
  assign bus.gw_msize    = iss_size;
  assign bus.wb_valid    = (state_q == WB);
  assign bus.wb_reg      = iss_reg;
  assign bus.wb_data     = wb_data_q;
  assign busy            = (count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_gpu_extmem_queue.sv
// Directed bench for gpu_extmem_queue: stimulus queues expected gateway
// transactions and writebacks; a monitor compares them as the DUT presents them.
module tb_gpu_extmem_queue;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, err_align, err_clr;

  gpu_extmem_queue_if #(.AW(24)) bus ();

  gpu_extmem_queue #(.DEPTH(2), .AW(24)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .err_align (err_align),
    .err_clr   (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] din;
    logic        memw;
    logic [1:0]  msize;
  } tx_t;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_t;

  tx_t exp_tx[$];
  wb_t exp_wb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each new gateway transaction and each new writeback
  logic ext_prev = 1'b0;
  logic wb_prev  = 1'b0;
  always @(negedge sys_clk) begin
    if (bus.gw_external && !ext_prev) begin
      if (exp_tx.size() == 0) begin
        check("tx_unexpected", 32'd1, 32'd0);
      end else begin
        tx_t t;
        t = exp_tx.pop_front();
        check("tx_addr",  {8'h0, bus.gw_addr}, {8'h0, t.addr});
        check("tx_din",   bus.gw_din, t.din);
        check("tx_memw",  {31'h0, bus.gw_memw}, {31'h0, t.memw});
        check("tx_msize", {30'h0, bus.gw_msize}, {30'h0, t.msize});
      end
    end
    if (bus.wb_valid && !wb_prev) begin
      if (exp_wb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t w;
        w = exp_wb.pop_front();
        check("wb_reg",  {27'h0, bus.wb_reg}, {27'h0, w.rg});
        check("wb_data", bus.wb_data, w.data);
      end
    end
    ext_prev <= bus.gw_external;
    wb_prev  <= bus.wb_valid;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [1:0] sz, input logic [23:0] a,
                      input logic [31:0] d, input logic [4:0] r);
    int unsigned n = 0;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_reg   = r;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.req_ready) check("push_timeout", 32'd0, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_ext();
    int unsigned n = 0;
    while (!bus.gw_external && n < 100) begin
      tick();
      n++;
    end
    if (!bus.gw_external) check("ext_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    bus.gw_done = 1'b1;
    tick();
    bus.gw_done = 1'b0;
  endtask

  task automatic add_tx(input logic [23:0] a, input logic [31:0] d, input logic m, input logic [1:0] s);
    tx_t t;
    t.addr = a; t.din = d; t.memw = m; t.msize = s;
    exp_tx.push_back(t);
  endtask

  task automatic add_wb(input logic [4:0] r, input logic [31:0] d);
    wb_t w;
    w.rg = r; w.data = d;
    exp_wb.push_back(w);
  endtask

  task automatic do_load(input logic [1:0] sz, input logic [23:0] a, input logic [4:0] r,
                         input logic [31:0] ld, input logic [31:0] expd);
    add_tx(a, 32'h0, 1'b0, sz);
    add_wb(r, expd);
    push(1'b0, sz, a, 32'h0, r);
    wait_ext();
    bus.load_data = ld;
    bus.xld_ready = 1'b1;
    tick();
    bus.xld_ready = 1'b0;
    check("load_wb_valid", {31'h0, bus.wb_valid}, 32'd1);
    tick();
    check("load_wb_done", {31'h0, bus.wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_reg = '0;
    bus.gw_done = 1'b0; bus.xld_ready = 1'b0; bus.load_data = '0;
    bus.wb_stall = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
    check("rst_gw_ext",    {31'h0, bus.gw_external}, 32'd0);
    check("rst_busy",      {31'h0, busy}, 32'd0);
    check("rst_wb_valid",  {31'h0, bus.wb_valid}, 32'd0);
    check("rst_err",       {31'h0, err_align}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Long store: issued one cycle after the push edge
    add_tx(24'h001000, 32'hDEADBEEF, 1'b1, 2'd2);
    push(1'b1, 2'd2, 24'h001000, 32'hDEADBEEF, 5'd0);
    check("st_ext_push_edge", {31'h0, bus.gw_external}, 32'd0);
    tick();
    check("st_ext_issue", {31'h0, bus.gw_external}, 32'd1);
    pulse_done();
    check("st_ext_done", {31'h0, bus.gw_external}, 32'd0);
    check("st_busy_done", {31'h0, busy}, 32'd0);

    // Byte load with writeback stalled for 3 cycles; gw_done mid-load ignored
    add_tx(24'h000203, 32'h0, 1'b0, 2'd0);
    add_wb(5'd7, 32'h000000A5);
    push(1'b0, 2'd0, 24'h000203, 32'h0, 5'd7);
    wait_ext();
    pulse_done();
    check("ld_ignore_done", {31'h0, bus.gw_external}, 32'd1);
    bus.load_data = 32'h123456A5;
    bus.xld_ready = 1'b1;
    bus.wb_stall  = 1'b1;
    tick();
    bus.xld_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wb_hold", {31'h0, bus.wb_valid}, 32'd1);
      if (i == 3) bus.wb_stall = 1'b0;
      tick();
    end
    check("wb_drop", {31'h0, bus.wb_valid}, 32'd0);

    // Word and long loads: zero-extension
    do_load(2'd1, 24'h000030, 5'd12, 32'hFFFF8001, 32'h00008001);
    do_load(2'd2, 24'h000034, 5'd31, 32'h89ABCDEF, 32'h89ABCDEF);

    // FIFO full with DEPTH 2, ordering, one-cycle gap between stores
    add_tx(24'h000010, 32'h11111111, 1'b1, 2'd2);
    add_tx(24'h000015, 32'h5A5A5A5A, 1'b1, 2'd0);
    add_tx(24'h000018, 32'h33333333, 1'b1, 2'd2);
    add_tx(24'h00001A, 32'hCAFECAFE, 1'b1, 2'd1);
    push(1'b1, 2'd2, 24'h000010, 32'h11111111, 5'd0);
    wait_ext();
    push(1'b1, 2'd0, 24'h000015, 32'h0000005A, 5'd0);
    check("full_ready_1", {31'h0, bus.req_ready}, 32'd1);
    push(1'b1, 2'd3, 24'h000018, 32'h33333333, 5'd0);
    check("full_ready_2", {31'h0, bus.req_ready}, 32'd0);
    bus.req_write = 1'b1; bus.req_size = 2'd1; bus.req_addr = 24'h00001A;
    bus.req_wdata = 32'h1234CAFE; bus.req_valid = 1'b1;
    repeat (2) tick();
    check("full_ignored", {31'h0, bus.req_ready}, 32'd0);
    pulse_done();
    check("gap_a", {31'h0, bus.gw_external}, 32'd0);
    push(1'b1, 2'd1, 24'h00001A, 32'h1234CAFE, 5'd0);
    for (int i = 0; i < 3; i++) begin
      wait_ext();
      pulse_done();
      check("gap_low", {31'h0, bus.gw_external}, 32'd0);
      if (i < 2) begin
        tick();
        check("gap_next", {31'h0, bus.gw_external}, 32'd1);
      end
    end
    check("fifo_drained_busy", {31'h0, busy}, 32'd0);

    // Misaligned word store, then clear; set wins over simultaneous clear
    add_tx(24'h000104, 32'hABCDABCD, 1'b1, 2'd1);
    push(1'b1, 2'd1, 24'h000105, 32'h0000ABCD, 5'd0);
    check("align_set", {31'h0, err_align}, 32'd1);
    wait_ext();
    pulse_done();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("align_clr", {31'h0, err_align}, 32'd0);
    add_tx(24'h000120, 32'h01020304, 1'b1, 2'd2);
    err_clr = 1'b1;
    push(1'b1, 2'd2, 24'h000122, 32'h01020304, 5'd0);
    err_clr = 1'b0;
    check("align_set_wins", {31'h0, err_align}, 32'd1);
    wait_ext();
    pulse_done();

    // Spurious strobes
    add_tx(24'h000020, 32'h0BADF00D, 1'b1, 2'd2);
    push(1'b1, 2'd2, 24'h000020, 32'h0BADF00D, 5'd0);
    wait_ext();
    bus.xld_ready = 1'b1;
    tick();
    bus.xld_ready = 1'b0;
    check("spur_xld_ext", {31'h0, bus.gw_external}, 32'd1);
    check("spur_xld_wb", {31'h0, bus.wb_valid}, 32'd0);
    pulse_done();
    pulse_done();
    bus.xld_ready = 1'b1;
    tick();
    bus.xld_ready = 1'b0;
    tick();
    check("spur_idle_ext", {31'h0, bus.gw_external}, 32'd0);
    check("spur_idle_wb", {31'h0, bus.wb_valid}, 32'd0);
    check("spur_idle_busy", {31'h0, busy}, 32'd0);

    // Reset mid-load discards in-flight and queued requests
    add_tx(24'h000040, 32'h0, 1'b0, 2'd2);
    push(1'b0, 2'd2, 24'h000040, 32'h0, 5'd3);
    wait_ext();
    push(1'b1, 2'd2, 24'h000044, 32'h55555555, 5'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ext", {31'h0, bus.gw_external}, 32'd0);
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_after_ready", {31'h0, bus.req_ready}, 32'd1);
    repeat (3) tick();
    check("rst_after_ext", {31'h0, bus.gw_external}, 32'd0);
    check("rst_after_busy", {31'h0, busy}, 32'd0);

    repeat (2) tick();
    check("tx_all_seen", exp_tx.size(), 32'd0);
    check("wb_all_seen", exp_wb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
